vm_txn_ctrl: RTL and testbench

//  Transaction controller for the two-product vending datapath. Accumulates coin credit and

---
 rtl/vm_pkg.sv | 35 +++
 rtl/vm_change_unit.sv | 60 ++++++
 rtl/vm_txn_ctrl.sv | 143 ++++++++++++++
 tb/tb_vm_txn_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending transaction controller.
//   - vm_state_e : controller state encoding, also driven onto present_state
//   - cash codes : cash_in encodings from the coin acceptor
//   - item codes : sel_item / disp_item encodings
//   - coin_units : maps a cash code to its value in 5tk units
package vm_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'b00,
      StCollect  = 2'b01,
      StDispense = 2'b10,
      StChange   = 2'b11
   } vm_state_e;

   localparam logic [1:0] CashNone = 2'b00;
   localparam logic [1:0] Cash5    = 2'b01;
   localparam logic [1:0] Cash10   = 2'b10;
   localparam logic [1:0] Cash20   = 2'b11;

   localparam logic ItemA = 1'b0;
   localparam logic ItemB = 1'b1;

   // Coin value in 5tk units: 5tk -> 1, 10tk -> 2, 20tk -> 4.
   function automatic logic [2:0] coin_units(input logic [1:0] cash);
      logic [2:0] units;
      case (cash)
         Cash5:   units = 3'd1;
         Cash10:  units = 3'd2;
         Cash20:  units = 3'd4;
         default: units = 3'd0;
      endcase
      return units;
   endfunction

endpackage

// File: rtl/vm_change_unit.sv
// Credit register for the vending controller.
// Holds the current credit, applies coin additions, purchase subtraction and the
// one-unit decrement used while paying out change. Also decides whether an incoming
// coin fits under MAX_CREDIT and raises a registered reject pulse when it does not.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   coin_allow    : controller is in a state that can take coins
//   coin_units    : value of the coin presented this cycle (0 = none)
//   sub_en        : subtract sub_units (purchase)
//   sub_units     : price of the item being bought
//   dec_en        : subtract one unit (one change coin emitted)
//   coin_ok       : combinational, coin this cycle is credited
//   coin_reject   : registered pulse, coin of the previous cycle was not credited
//   credit        : registered credit in 5tk units
module vm_change_unit #(
   parameter int unsigned CREDIT_W   = 4,
   parameter int unsigned MAX_CREDIT = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                coin_allow,
   input  logic [2:0]          coin_units,
   input  logic                sub_en,
   input  logic [CREDIT_W-1:0] sub_units,
   input  logic                dec_en,
   output logic                coin_ok,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit
);

   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                reject_q, reject_d;
   logic [CREDIT_W:0]   coin_sum;

   always_comb begin
      // One extra bit so the overflow check itself can never wrap.
      coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_units);
      coin_ok  = coin_allow && (coin_units != 3'd0) &&
                 (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT));
      reject_d = (coin_units != 3'd0) && !coin_ok;
      credit_d = credit_q
               + (coin_ok ? CREDIT_W'(coin_units) : '0)
               - (sub_en  ? sub_units : '0)
               - CREDIT_W'(dec_en);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         credit_q <= '0;
         reject_q <= 1'b0;
      end else begin
         credit_q <= credit_d;
         reject_q <= reject_d;
      end
   end

   assign credit      = credit_q;
   assign coin_reject = reject_q;

endmodule

// File: rtl/vm_txn_ctrl.sv
// Transaction controller for the two-product vending datapath.
// Collects coin credit, grants a purchase when credit covers the price, runs one
// dispense handshake and then returns remaining credit as 5tk coin pulses.
// Optional feature: define VM_TIMEOUT_EN to refund automatically after TIMEOUT_CYC
// idle cycles in COLLECT; without it COLLECT waits indefinitely.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   cash_in       : coin code, one coin per cycle
//   sel_valid     : one-cycle purchase request, sel_item picks A (0) or B (1)
//   cancel        : one-cycle refund request
//   disp_req      : dispense request, held until the cycle after disp_ack
//   disp_item     : item being dispensed
//   disp_ack      : dispenser done, only looked at while disp_req=1
//   coin_out      : one 5tk change coin per cycle asserted
//   coin_reject   : pulse, coin of the previous cycle was not credited
//   credit        : current credit in 5tk units
//   present_state : 00 IDLE, 01 COLLECT, 10 DISPENSE, 11 CHANGE
module vm_txn_ctrl
   import vm_pkg::*;
#(
   parameter int unsigned CREDIT_W    = 4,
   parameter int unsigned MAX_CREDIT  = 12,
   parameter int unsigned PRICE_A     = 2,
   parameter int unsigned PRICE_B     = 3
`ifdef VM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          cash_in,
   input  logic                sel_valid,
   input  logic                sel_item,
   input  logic                cancel,
   output logic                disp_req,
   output logic                disp_item,
   input  logic                disp_ack,
   output logic                coin_out,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          present_state
);

   vm_state_e           state_q, state_d;
   logic                item_q, item_d;
   logic                coin_ok;
   logic                coin_allow;
   logic                sub_en;
   logic                dec_en;
   logic                timeout_hit;
   logic [CREDIT_W-1:0] price;

   assign coin_allow = (state_q == StIdle) || (state_q == StCollect);
   assign price      = (sel_item == ItemB) ? CREDIT_W'(PRICE_B) : CREDIT_W'(PRICE_A);

   vm_change_unit #(
      .CREDIT_W   (CREDIT_W),
      .MAX_CREDIT (MAX_CREDIT)
   ) u_change (
      .clock       (clock),
      .reset       (reset),
      .coin_allow  (coin_allow),
      .coin_units  (coin_units(cash_in)),
      .sub_en      (sub_en),
      .sub_units   (price),
      .dec_en      (dec_en),
      .coin_ok     (coin_ok),
      .coin_reject (coin_reject),
      .credit      (credit)
   );

   always_comb begin
      state_d = state_q;
      item_d  = item_q;
      sub_en  = 1'b0;
      dec_en  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (coin_ok) state_d = StCollect;
         end
         StCollect: begin
            // A purchase that can be paid for beats a simultaneous cancel.
            if (sel_valid && (credit >= price)) begin
               state_d = StDispense;
               item_d  = sel_item;
               sub_en  = 1'b1;
            end else if (cancel || timeout_hit) begin
               state_d = StChange;
            end
         end
         StDispense: begin
            if (disp_ack) state_d = (credit != '0) ? StChange : StIdle;
         end
         StChange: begin
            dec_en = (credit != '0);
            // Leave on the cycle that emits the last coin.
            if (credit <= CREDIT_W'(1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef VM_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            activity;

   assign activity    = coin_ok || sel_valid || cancel;
   assign timeout_hit = (state_q == StCollect) && !activity &&
                        (tmo_q == TmoW'(TIMEOUT_CYC - 1));

   // Counts idle COLLECT cycles; zero on entry, on any activity and outside COLLECT.
   always_comb begin
      tmo_d = '0;
      if ((state_q == StCollect) && (state_d == StCollect) && !activity) tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         item_q  <= ItemA;
      end else begin
         state_q <= state_d;
         item_q  <= item_d;
      end
   end

   assign present_state = state_q;
   assign disp_req      = (state_q == StDispense);
   assign disp_item     = item_q;
   assign coin_out      = (state_q == StChange) && (credit != '0);

endmodule

// File: tb/tb_vm_txn_ctrl.sv
// Self-checking bench for vm_txn_ctrl: directed vector table, randomized run against a
// behavioural model, and hand-written timeout sequence.
module tb_vm_txn_ctrl;

   localparam int MaxCredit = 12;
   localparam int PriceA    = 2;
   localparam int PriceB    = 3;
   localparam int TmoCyc    = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] cash_in;
   logic       sel_valid;
   logic       sel_item;
   logic       cancel;
   logic       disp_req;
   logic       disp_item;
   logic       disp_ack;
   logic       coin_out;
   logic       coin_reject;
   logic [3:0] credit;
   logic [1:0] present_state;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_phase;   // 0 idle, 1 collect, 2 dispense, 3 change
   int m_credit;
   int m_item;
   int m_rej;
   int m_idle;

   typedef struct {
      logic [1:0] cash;
      logic       sv, si, cn, ack, rst;
      int         st, cr, req, item, cout, rej;
   } vec_t;

   vec_t vq[$];

   always #5 clock = ~clock;

   vm_txn_ctrl #(
      .CREDIT_W (4)
`ifdef VM_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (TmoCyc)
`endif
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cash_in       (cash_in),
      .sel_valid     (sel_valid),
      .sel_item      (sel_item),
      .cancel        (cancel),
      .disp_req      (disp_req),
      .disp_item     (disp_item),
      .disp_ack      (disp_ack),
      .coin_out      (coin_out),
      .coin_reject   (coin_reject),
      .credit        (credit),
      .present_state (present_state)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one call per clock with the inputs of that cycle.
   task automatic model_step(input logic [1:0] c, input logic v, s, n, a, r);
      int  val;
      int  price;
      bit  take;
      if (r) begin
         m_phase = 0; m_credit = 0; m_item = 0; m_rej = 0; m_idle = 0;
         return;
      end
      val   = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 4 : 0;
      take  = (m_phase <= 1) && (val > 0) && (m_credit + val <= MaxCredit);
      m_rej = ((val > 0) && !take) ? 1 : 0;
      if (m_phase != 1) m_idle = 0;
      case (m_phase)
         0: if (take) begin m_phase = 1; m_credit = val; end
         1: begin
            price = s ? PriceB : PriceA;
            if (v && m_credit >= price) begin
               m_credit = m_credit + (take ? val : 0) - price;
               m_item   = s;
               m_phase  = 2;
            end else begin
               if (take) m_credit += val;
               if (n) m_phase = 3;
`ifdef VM_TIMEOUT_EN
               else if (take || v) m_idle = 0;
               else begin
                  m_idle++;
                  if (m_idle == TmoCyc) m_phase = 3;
               end
`endif
            end
         end
         2: if (a) m_phase = (m_credit > 0) ? 3 : 0;
         default: begin
            if (m_credit > 0) m_credit--;
            if (m_credit == 0) m_phase = 0;
         end
      endcase
   endtask

   task automatic step(input logic [1:0] c, input logic v, s, n, a, r);
      cash_in = c; sel_valid = v; sel_item = s; cancel = n; disp_ack = a; reset = r;
      model_step(c, v, s, n, a, r);
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input int st, cr, req, item, cout, rej);
      chk({tag, " state"},  int'(present_state), st);
      chk({tag, " credit"}, int'(credit), cr);
      chk({tag, " req"},    int'(disp_req), req);
      chk({tag, " item"},   int'(disp_item), item);
      chk({tag, " cout"},   int'(coin_out), cout);
      chk({tag, " rej"},    int'(coin_reject), rej);
   endtask

   task automatic add(input logic [1:0] c, input logic v, s, n, a, r,
                      input int st, cr, req, item, cout, rej);
      vec_t e;
      e.cash = c; e.sv = v; e.si = s; e.cn = n; e.ack = a; e.rst = r;
      e.st = st; e.cr = cr; e.req = req; e.item = item; e.cout = cout; e.rej = rej;
      vq.push_back(e);
   endtask

   initial begin
      int n;
      int pulses;
      logic [1:0] c;
      logic r;

      cash_in = 2'd0; sel_valid = 0; sel_item = 0; cancel = 0; disp_ack = 0; reset = 1;

      //   cash sv si cn ack rst | state credit req item cout rej
      add(0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0);  // reset
      add(2, 0, 0, 0, 0, 0,  1,  2, 0, 0, 0, 0);  // 10tk
      add(0, 1, 0, 0, 0, 0,  2,  0, 1, 0, 0, 0);  // buy A
      add(0, 0, 0, 0, 0, 0,  2,  0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,  2,  0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0);  // ack, no change
      add(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
      add(3, 0, 0, 0, 0, 0,  1,  4, 0, 0, 0, 0);  // 20tk
      add(0, 1, 1, 0, 0, 0,  2,  1, 1, 1, 0, 0);  // buy B
      add(0, 0, 0, 0, 1, 0,  3,  1, 0, 1, 1, 0);  // one change coin
      add(0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0,  1,  1, 0, 1, 0, 0);  // 5tk
      add(0, 1, 1, 0, 0, 0,  1,  1, 0, 1, 0, 0);  // B too expensive
      add(0, 0, 0, 1, 0, 0,  3,  1, 0, 1, 1, 0);  // cancel
      add(0, 0, 0, 0, 0, 0,  0,  0, 0, 1, 0, 0);
      add(3, 0, 0, 0, 0, 0,  1,  4, 0, 1, 0, 0);
      add(3, 0, 0, 0, 0, 0,  1,  8, 0, 1, 0, 0);
      add(2, 0, 0, 0, 0, 0,  1, 10, 0, 1, 0, 0);
      add(3, 0, 0, 0, 0, 0,  1, 10, 0, 1, 0, 1);  // 14 > max
      add(2, 0, 0, 0, 0, 0,  1, 12, 0, 1, 0, 0);  // exactly max
      add(1, 0, 0, 0, 0, 0,  1, 12, 0, 1, 0, 1);
      add(1, 1, 0, 0, 0, 0,  2, 10, 1, 0, 0, 1);  // buy A, coin over max
      add(2, 0, 0, 0, 0, 0,  2, 10, 1, 0, 0, 1);  // coin in DISPENSE
      add(0, 0, 0, 0, 1, 0,  3, 10, 0, 0, 1, 0);
      add(1, 0, 0, 0, 0, 0,  3,  9, 0, 0, 1, 1);  // coin in CHANGE
      add(0, 0, 0, 0, 0, 0,  3,  8, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,  3,  7, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,  3,  6, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,  3,  5, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 0, 0);  // reset mid-change
      add(2, 0, 0, 0, 0, 0,  1,  2, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0,  3,  3, 0, 0, 1, 0);  // coin + cancel
      add(0, 0, 0, 0, 0, 0,  3,  2, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,  3,  1, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,  1,  1, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0,  3,  1, 0, 0, 1, 0);  // sel short, cancel wins
      add(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
      add(2, 0, 0, 0, 0, 0,  1,  2, 0, 0, 0, 0);
      add(0, 1, 0, 1, 0, 0,  2,  0, 1, 0, 0, 0);  // sel affordable, wins
      add(0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0);
      add(0, 1, 1, 1, 0, 0,  0,  0, 0, 0, 0, 0);  // ignored in IDLE
      add(2, 0, 0, 0, 0, 0,  1,  2, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,  2,  0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 1, 1,  0,  0, 0, 0, 0, 0);  // reset mid-handshake

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].cash, vq[i].sv, vq[i].si, vq[i].cn, vq[i].ack, vq[i].rst);
         check_all($sformatf("vec%0d", i), vq[i].st, vq[i].cr, vq[i].req,
                   vq[i].item, vq[i].cout, vq[i].rej);
      end

      // Randomized run against the model
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         c = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) c = 2'd0;
         r = ($urandom_range(0, 199) == 0);
         step(c, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0), r);
         check_all("rand", m_phase, m_credit, (m_phase == 2) ? 1 : 0, m_item,
                   (m_phase == 3 && m_credit > 0) ? 1 : 0, m_rej);
      end

      // Idle COLLECT behaviour
      step(0, 0, 0, 0, 0, 1);
      step(2, 0, 0, 0, 0, 0);
      chk("collect_entry", int'(present_state), 1);
`ifdef VM_TIMEOUT_EN
      n = 0;
      while (present_state != 2'd3 && n < 20) begin
         step(0, 0, 0, 0, 0, 0);
         n++;
      end
      chk("timeout_cycles", n, TmoCyc);
      pulses = 0;
      n = 0;
      while (present_state != 2'd0 && n < 10) begin
         if (coin_out) pulses++;
         step(0, 0, 0, 0, 0, 0);
         n++;
      end
      chk("timeout_refund_pulses", pulses, 2);
      chk("timeout_final_credit", int'(credit), 0);
`else
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         step(0, 0, 0, 0, 0, 0);
         if (coin_out) pulses++;
      end
      chk("no_timeout_state", int'(present_state), 1);
      chk("no_timeout_credit", int'(credit), 2);
      chk("no_timeout_pulses", pulses, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
